// File: rtl/fetch_block.sv
// Instruction fetch stage: pc register, IF/ID pipeline register and a
// RUN/HALTED state machine that stops fetching after a halt word.
module fetch_block #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] instruction_in,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_e;

  typedef enum logic [2:0] {
    SRC_BR, SRC_IDLE, SRC_JMP, SRC_HOLD, SRC_SEQ
  } src_e;

  state_e      state_q, state_d;
  src_e        src;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] p4_q, p4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  // Redirect priority; HALTED only listens to branch_taken.
  always_comb begin
    src = SRC_SEQ;
    priority case (1'b1)
      branch_taken:        src = SRC_BR;
      (state_q == HALTED): src = SRC_IDLE;
      jump:                src = SRC_JMP;
      stall:               src = SRC_HOLD;
      default:             src = SRC_SEQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (src)
      SRC_BR:  state_d = RUN;
      SRC_SEQ: if (instruction_in == HALT_WORD)
                 state_d = HALTED;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    p4_d    = p4_q;
    valid_d = valid_q;
    unique case (src)
      SRC_BR: begin
        pc_d    = branch_target & ~32'h3;
        valid_d = 1'b0;
      end
      SRC_IDLE: valid_d = 1'b0;
      SRC_JMP: begin
        pc_d    = {p4_q[31:28], jump_index, 2'b00};
        valid_d = 1'b0;
      end
      SRC_HOLD: valid_d = valid_q;
      SRC_SEQ: begin
        pc_d    = pc_inc;
        ir_d    = instruction_in;
        p4_d    = pc_inc;
        valid_d = 1'b1;
      end
      default: valid_d = valid_q;
    endcase
  end

  assign cnt_d = (src == SRC_SEQ && cnt_q != '1)
               ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      p4_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      p4_q    <= p4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    halted            = (state_q == HALTED);
    pc                = pc_q;
    if_id_instruction = ir_q;
    if_id_pc_plus4    = p4_q;
    if_id_valid       = valid_q;
    fetch_count       = cnt_q;
  end

endmodule

// File: tb/tb_fetch_block.sv
// Self-checking bench for fetch_block: directed scenarios with literal
// expectations, then random redirects/stalls/resets against a model.
module tb_fetch_block;

  localparam logic [31:0] HALT = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_target, instruction_in;
  logic [25:0] jump_index;
  logic [31:0] pc, if_id_instruction, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, halted;

  fetch_block dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .instruction_in(instruction_in), .pc(pc),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  bit          rnd_mode = 0;

  logic [31:0] m_pc, m_ir, m_p4, m_cnt;
  logic        m_v, m_halt;
  bit          chk_en = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    if ($isunknown(a)) return 32'h0;
    if (mem.exists(a)) return mem[a];
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (rnd_mode && h[7:4] == 4'h0) return HALT;
    return h | 32'h3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference behaviour for one rising edge.
  task automatic model_step();
    logic [31:0] nxt;
    if (reset) begin
      m_pc = 32'h0; m_ir = 0; m_p4 = 0;
      m_v = 0; m_cnt = 0; m_halt = 0;
    end else if (branch_taken) begin
      m_pc = {branch_target[31:2], 2'b00};
      m_v = 0; m_halt = 0;
    end else if (m_halt) begin
      m_v = 0;
    end else if (jump) begin
      m_pc = {m_p4[31:28], jump_index, 2'b00};
      m_v = 0;
    end else if (!stall) begin
      nxt = m_pc + 4;
      m_ir = instruction_in; m_p4 = nxt; m_pc = nxt; m_v = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (instruction_in == HALT) m_halt = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("valid", {31'b0, if_id_valid}, {31'b0, m_v});
      chk("halted", {31'b0, halted}, {31'b0, m_halt});
      chk("count", fetch_count, m_cnt);
      chk("ir", if_id_instruction, m_ir);
      chk("pc4", if_id_pc_plus4, m_p4);
    end
  end

  task automatic cyc(input logic r, s, b, j,
                     input logic [31:0] bt,
                     input logic [25:0] ji);
    reset = r; stall = s; branch_taken = b; jump = j;
    branch_target = bt; jump_index = ji;
    instruction_in = word_at(pc);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic seq();
    cyc(0, 0, 0, 0, 32'h0, 26'h0);
  endtask

  task automatic br(input logic [31:0] t);
    cyc(0, 0, 1, 0, t, 26'h0);
  endtask

  initial begin
    logic [31:0] t;
    mem[32'h0]  = 32'h2008_0005;
    mem[32'h14] = HALT;
    #1;
    cyc(1, 1, 1, 1, 32'h1234_5678, 26'h3FF_FFFF);
    chk_en = 1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    seq();
    chk("d_ir", if_id_instruction, 32'h2008_0005);
    chk("d_pc4", if_id_pc_plus4, 32'h4);
    chk("d_v", {31'b0, if_id_valid}, 32'h1);
    seq();
    chk("d_pc8", pc, 32'h8);
    cyc(0, 1, 0, 0, 32'h0, 26'h0);
    cyc(0, 1, 0, 0, 32'h0, 26'h0);
    chk("stall_pc", pc, 32'h8);
    chk("stall_cnt", fetch_count, 32'h2);
    seq();
    chk("rel_pc", pc, 32'hC);
    chk("rel_cnt", fetch_count, 32'h3);
    seq();
    chk("pc16", pc, 32'h10);
    cyc(0, 1, 1, 1, 32'h0000_0FFE, 26'h1);
    chk("br_pc", pc, 32'h0000_0FFC);
    chk("br_v", {31'b0, if_id_valid}, 32'h0);
    br(32'h4000_000C);
    seq();
    chk("j_pre", if_id_pc_plus4, 32'h4000_0010);
    cyc(0, 0, 0, 1, 32'h0, 26'h000_0100);
    chk("j_pc", pc, 32'h4000_0400);
    chk("j_v", {31'b0, if_id_valid}, 32'h0);
    br(32'h14);
    seq();
    chk("h_halt", {31'b0, halted}, 32'h1);
    chk("h_pc", pc, 32'h18);
    chk("h_ir", if_id_instruction, HALT);
    chk("h_v1", {31'b0, if_id_valid}, 32'h1);
    cyc(0, 1, 0, 1, 32'h0, 26'h55);
    chk("h_v0", {31'b0, if_id_valid}, 32'h0);
    chk("h_hold", pc, 32'h18);
    cyc(0, 0, 0, 1, 32'h0, 26'h77);
    chk("h_jmp", pc, 32'h18);
    br(32'h40);
    chk("h_br", pc, 32'h40);
    chk("h_run", {31'b0, halted}, 32'h0);
    br(32'hFFFF_FFFC);
    seq();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_p4", if_id_pc_plus4, 32'h0);
    br(32'h14);
    seq();
    cyc(1, 1, 0, 0, 32'h0, 26'h0);
    chk("hr_pc", pc, 32'h0);
    chk("hr_halt", {31'b0, halted}, 32'h0);
    chk("hr_cnt", fetch_count, 32'h0);

    mem.delete();
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 7) == 0)
        ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
        : 32'($urandom_range(0, 1023));
      cyc($urandom_range(0, 59) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) == 0,
          t, 26'($urandom));
    end
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
